// File: rtl/n1_pkg.sv
// n1_pkg: shared opcodes, FSM states and instruction field layout for the N1 core
package n1_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_e;
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_ST   = 4'd2,
        OP_LD   = 4'd3,
        OP_OUT  = 4'd4,
        OP_HALT = 4'd5,
        OP_ADD  = 4'd6,
        OP_SUB  = 4'd7,
        OP_JMP  = 4'd8,
        OP_JZ   = 4'd9
    } op_e;
    localparam int OP_LSB  = 12;
    localparam int OP_W    = 4;
    localparam int RD_LSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;
    function automatic logic [15:0] enc(logic [3:0] op, logic [1:0] rd, logic [1:0] rs, logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction
endpackage

// File: rtl/n1_if.sv
// n1_if: host program port and run/observe signals of the N1 core
interface n1_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 7
);
    logic              run;
    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic [DATA_W-1:0] prog_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              halted;
    logic [AW-1:0]     pc_o;
    modport slave (
        input  run, prog_we, prog_addr, prog_wdata,
        output prog_rdata, out_valid, out_data, halted, pc_o
    );
    modport master (
        output run, prog_we, prog_addr, prog_wdata,
        input  prog_rdata, out_valid, out_data, halted, pc_o
    );
endinterface

// File: rtl/n1_ram.sv
// n1_ram: single-port RAM, synchronous write and one-cycle registered read
module n1_ram #(
    parameter int DATA_W = 16,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**AW];
    logic [DATA_W-1:0] r_rdata;
    // write port and registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/n1_cpu.sv
// n1_cpu: tiny accumulator-style core; branches enabled with N1_BRANCH_EN
module n1_cpu
    import n1_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RAM_WORDS = 128,
    parameter int NUM_REGS  = 4
) (
    input logic clk,
    input logic rst_n,
    n1_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int RW = (NUM_REGS == 4) ? 2 : 1;
    state_e            r_state, w_next;
    logic [AW-1:0]     r_pc, w_pc_next, w_addr, w_ram_addr;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_out_data, w_ram_rdata, w_ram_wdata;
    logic              r_out_valid, r_host, w_host, w_ram_we, w_taken;
    logic [15:0]       r_ir, w_ins;
    logic [3:0]        w_op;
    logic [RW-1:0]     w_rd, w_rs;
    // the instruction arrives from RAM during EXEC and is held in r_ir for MEM
    assign w_ins  = (r_state == EXEC) ? w_ram_rdata[15:0] : r_ir;
    assign w_op   = w_ins[OP_LSB +: OP_W];
    assign w_rd   = w_ins[RD_LSB +: RW];
    assign w_rs   = w_ins[RS_LSB +: RW];
    assign w_addr = w_ins[IMM_LSB +: AW];
`ifdef N1_BRANCH_EN
    assign w_taken = (w_op == OP_JMP) || (w_op == OP_JZ && r_regs[w_rd] == '0);
`else
    assign w_taken = 1'b0;
`endif
    // HALT keeps pc on its own address so the halt location stays visible
    assign w_pc_next = (w_op == OP_HALT) ? r_pc : w_taken ? w_addr : r_pc + 1'b1;
    // host owns the RAM whenever the core is parked or held in reset
    assign w_host      = !rst_n || r_state == IDLE || r_state == HALT;
    assign w_ram_we    = w_host ? bus.prog_we : (r_state == EXEC && w_op == OP_ST);
    assign w_ram_addr  = w_host ? bus.prog_addr : (r_state == FETCH) ? r_pc : w_addr;
    assign w_ram_wdata = w_host ? bus.prog_wdata : r_regs[w_rd];
    n1_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.run ? FETCH : IDLE;
            FETCH:   w_next = EXEC;
            EXEC:    w_next = (w_op == OP_LD || w_op == OP_OUT) ? MEM : (w_op == OP_HALT) ? HALT : FETCH;
            MEM:     w_next = FETCH;
            HALT:    w_next = bus.run ? HALT : IDLE;
            default: w_next = IDLE;
        endcase
    end
    // datapath: pc, register file and output port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == EXEC) begin
                r_ir <= w_ins;
                r_pc <= w_pc_next;
                if (w_op == OP_LDI)      r_regs[w_rd] <= DATA_W'(w_ins[IMM_LSB +: IMM_W]);
                else if (w_op == OP_ADD) r_regs[w_rd] <= r_regs[w_rd] + r_regs[w_rs];
                else if (w_op == OP_SUB) r_regs[w_rd] <= r_regs[w_rd] - r_regs[w_rs];
            end else if (r_state == MEM) begin
                if (w_op == OP_LD) begin
                    r_regs[w_rd] <= w_ram_rdata;
                end else begin
                    r_out_data  <= w_ram_rdata;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end
    // remembers whether the last read was a host read, so prog_rdata is masked otherwise
    always_ff @(posedge clk) r_host <= w_host;
    assign bus.prog_rdata = r_host ? w_ram_rdata : '0;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.halted     = (r_state == HALT);
    assign bus.pc_o       = r_pc;
endmodule

// File: doc/n1_cpu.md
N1_CPU -- requirements
Module: n1_cpu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register and RAM word width, legal values 16..32.
REQ-002 The block SHALL have parameter RAM_WORDS, default 128, meaning RAM depth in words, power of two, 16..256; AW = clog2(RAM_WORDS).
REQ-003 The block SHALL have parameter NUM_REGS, default 4, meaning general-purpose register count, legal values 2 or 4.
REQ-004 The block SHALL have port clk, input, 1, clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 The block SHALL have port run, input, 1, level that starts execution from IDLE.
REQ-007 The block SHALL have port prog_we, input, 1, host write strobe for the program port.
REQ-008 The block SHALL have port prog_addr, input, AW, host word address.
REQ-009 The block SHALL have port prog_wdata, input, DATA_W, host write data.
REQ-010 The block SHALL have port prog_rdata, output, DATA_W, host read data, one cycle after prog_addr.
REQ-011 The block SHALL have port out_valid, output, 1, one-cycle strobe accompanying out_data.
REQ-012 The block SHALL have port out_data, output, DATA_W, value emitted by OUT.
REQ-013 The block SHALL have port halted, output, 1, high while in HALT.
REQ-014 The block SHALL have port pc_o, output, AW, current program counter.

Function
REQ-015 Instruction fields SHALL be: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm/addr. RAM addresses SHALL be addr[AW-1:0]. Register indices SHALL be taken modulo NUM_REGS. Bits above 15 SHALL be ignored.
REQ-016 The opcodes SHALL be:
- 0 NOP
- 1 LDI: rd<=zero-extended imm
- 2 ST: RAM[addr]<=rd
- 3 LD: rd<=RAM[addr]
- 4 OUT: out_data<=RAM[addr]
- 5 HALT
- 6 ADD: rd<=rd+rs
- 7 SUB: rd<=rd-rs
- 8 JMP: pc<=addr
- 9 JZ: pc<=addr if rd==0
- all others: NOP
REQ-017 ADD and SUB SHALL wrap modulo 2^DATA_W, with no flags.
REQ-018 The state machine SHALL be:
- IDLE -> FETCH when run=1
- FETCH (issue sync read of RAM[pc]) -> EXEC
- EXEC -> MEM for LD and OUT, -> HALT for HALT, else -> FETCH
- MEM -> FETCH
- HALT -> IDLE when run=0
REQ-019 Non-memory instructions SHALL take 2 cycles. LD and OUT SHALL take 3 cycles.
REQ-020 In EXEC, pc SHALL become the jump target if a jump is taken, otherwise pc+1. pc SHALL wrap from RAM_WORDS-1 to 0. pc SHALL hold in HALT.
REQ-021 out_valid SHALL pulse for exactly one cycle, on the cycle out_data updates, at the end of MEM for OUT. out_data SHALL hold its value otherwise.
REQ-022 The program port SHALL be serviced only in IDLE, HALT, or while rst_n=0. prog_we SHALL be ignored in all other states. prog_rdata SHALL be 0 while the core owns the RAM.
REQ-023 A ST whose address equals the next fetch address SHALL be visible to that fetch, because the write completes before the read.
REQ-024 Deasserting run mid-program SHALL NOT stop execution; only HALT ends a run.

Reset
REQ-025 When rst_n=0 the block SHALL set: state=IDLE; pc, registers, out_data, and out_valid to 0; halted to 0.
REQ-026 RAM contents SHALL NOT be cleared by reset. Reset SHALL abort any in-flight instruction with no RAM write.

Configuration
REQ-027 With macro N1_BRANCH_EN defined, JMP and JZ SHALL behave per REQ-016 and REQ-020. Without it, opcodes 8 and 9 SHALL execute as NOP with pc+1.

Structure
REQ-028 Package n1_pkg SHALL hold the opcode enum, the state enum (IDLE, FETCH, EXEC, MEM, HALT), and the instruction field bit-position constants.
REQ-029 RAM SHALL be a sub-module n1_ram: single-port synchronous read and write, one-cycle read latency, port mux in n1_cpu.

Verification
REQ-030 The bench SHALL load program LDI r1,0x2A; ST r1,0x40; OUT 0x40; HALT and set run=1. Required response: one out_valid with out_data=0x002A, then halted=1, 9 cycles after FETCH start.
REQ-031 The bench SHALL run LDI r0,1; LDI r1,2; SUB r0,r1; ST r0,0x50; HALT. Required response: RAM[0x50] reads back 0xFFFF (DATA_W=16) via the program port.
REQ-032 With N1_BRANCH_EN, the bench SHALL run LDI r2,0; JZ r2,0x10, with OUT at 0x10. Required response: out_valid fires. Without N1_BRANCH_EN, pc=2 follows the JZ.
REQ-033 With RAM_WORDS=16, the bench SHALL fill all words with NOP except a HALT at word 3 and start with pc at word 15. Required response: pc wraps 15->0, and the block halts at pc_o=3.
REQ-034 The bench SHALL assert rst_n=0 during the MEM cycle of an LD. Required response: all registers are 0 and state is IDLE. prog_we while running SHALL leave RAM unchanged.
